// File: rtl/decode.sv
// RV32I decode stage: combinational field decode feeding one ID/EX output register,
// with a two-state FSM that inserts two bubbles on a load-use hazard.
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic [3:0]  alu_op_o,
  output logic        reg_we_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        illegal_o
);

  typedef enum logic {RUN, LU_WAIT} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t  state_q, state_d;
  bundle_t out_q, out_d;
  bundle_t dec;
  logic    writes, use_rs1, use_rs2, hazard;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd_f   = instr_i[11:7];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec       = '0;
    dec.valid = instr_valid_i;
    dec.pc    = pc_i;
    writes    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    unique case (opcode)
      OP_LUI, OP_AUIPC: begin writes = 1'b1; dec.imm = imm_u; end
      OP_JAL:    begin writes = 1'b1; dec.jump = 1'b1; dec.imm = imm_j; end
      OP_JALR:   begin writes = 1'b1; dec.jump = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; end
      OP_BRANCH: begin dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b; end
      OP_LOAD:   begin writes = 1'b1; dec.mem_re = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; end
      OP_STORE:  begin dec.mem_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_s; end
      OP_IMM: begin
        writes     = 1'b1;
        use_rs1    = 1'b1;
        dec.imm    = imm_i;
        // Only the shift-right pair distinguishes SRLI/SRAI through instr[30].
        dec.alu_op = {(funct3 == 3'b101) & instr_i[30], funct3};
      end
      OP_OP: begin
        writes     = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.alu_op = {instr_i[30], funct3};
      end
      OP_FENCE: ;
      default:  dec.illegal = 1'b1;
    endcase
    dec.reg_we = writes && (rd_f != 5'd0);
    dec.rd     = dec.reg_we ? rd_f  : 5'd0;
    dec.rs1    = use_rs1    ? rs1_f : 5'd0;
    dec.rs2    = use_rs2    ? rs2_f : 5'd0;
  end

  // Unused source fields are already zeroed, so a zero index never matches.
  assign hazard = instr_valid_i && out_q.valid && out_q.mem_re &&
                  (((dec.rs1 != 5'd0) && (dec.rs1 == out_q.rd)) ||
                   ((dec.rs2 != 5'd0) && (dec.rs2 == out_q.rd)));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    stall_o = 1'b0;
    if (flush_i) begin
      out_d   = '0;
      state_d = RUN;
    end else if (stall_i) begin
      stall_o = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hazard) begin
            out_d   = '0;
            stall_o = 1'b1;
            state_d = LU_WAIT;
          end else begin
            out_d = instr_valid_i ? dec : '0;
          end
        end
        LU_WAIT: begin
          out_d   = '0;
          stall_o = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    if (rst) stall_o = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign valid_o   = out_q.valid;
  assign pc_o      = out_q.pc;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign rd_o      = out_q.rd;
  assign imm_o     = out_q.imm;
  assign alu_op_o  = out_q.alu_op;
  assign reg_we_o  = out_q.reg_we;
  assign mem_re_o  = out_q.mem_re;
  assign mem_we_o  = out_q.mem_we;
  assign branch_o  = out_q.branch;
  assign jump_o    = out_q.jump;
  assign illegal_o = out_q.illegal;

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it has no parameters.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 instr_i  input  32  RV32I instruction word from fetch.
REQ-005 instr_valid_i  input  1  instr_i/pc_i valid this cycle.
REQ-006 pc_i  input  32  PC of instr_i.
REQ-007 stall_i  input  1  execute cannot accept; hold outputs.
REQ-008 flush_i  input  1  branch/jump redirect; discard in-flight work.
REQ-009 stall_o  output  1  to fetch stall input; fetch holds instr_i/pc_i/instr_valid_i next cycle.
REQ-010 valid_o  output  1  registered: decoded bundle valid (0 = bubble).
REQ-011 pc_o  output  32  registered PC of decoded instruction.
REQ-012 rs1_o, rs2_o, rd_o  output  5 each  registered register indices.
REQ-013 imm_o  output  32  registered sign-extended immediate.
REQ-014 alu_op_o  output  4  registered {funct7[5], funct3} ALU code.
REQ-015 reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o  output  1 each  registered control flags.

Function
REQ-016 All outputs except stall_o SHALL come from one output register (ID/EX); stall_o SHALL be combinational.
REQ-017 Latency: valid instr_i accepted in cycle N SHALL appear on outputs in cycle N+1.
REQ-018 Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011 decoded; FENCE 0001111 SHALL decode as NOP (valid, all flags 0); any other opcode SHALL set illegal_o=1 with all other flags 0.
REQ-019 Immediates: I/S/B/U/J formats per RV32I, sign-extended from instr[31]; B and J bit 0 = 0; U low 12 bits = 0; R-type imm_o=0.
REQ-020 alu_op_o = {instr[30], funct3} for OP; for OP-IMM bit 3 = instr[30] only when funct3=101, else 0; all other opcodes 4'b0000 (ADD).
REQ-021 reg_we_o=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; rd_o SHALL be forced to 0 when reg_we_o=0; reg_we_o SHALL be 0 when rd=0.
REQ-022 jump_o for JAL/JALR; branch_o for BRANCH; mem_re_o for LOAD; mem_we_o for STORE.
REQ-023 rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 used by BRANCH, STORE, OP; unused rs fields SHALL output 0.
REQ-024 Load-use hazard: valid instr_i uses nonzero rs equal to rd_o while valid_o=1 and mem_re_o=1.
REQ-025 FSM states RUN, LU_WAIT; reset state RUN.
REQ-026 RUN, hazard, no stall_i/flush_i: register bubble (valid_o=0, all flags 0), stall_o=1, go LU_WAIT.
REQ-027 LU_WAIT, no stall_i/flush_i: register second bubble, stall_o=1, go RUN; load-use therefore costs exactly 2 bubbles.
REQ-028 RUN, no hazard, no stall_i/flush_i: register decoded instr_i with valid_o=instr_valid_i; stall_o=0.
REQ-029 stall_i=1 (no flush_i): output register and FSM state SHALL hold; stall_o=1.
REQ-030 flush_i=1 SHALL have priority over stall_i and hazard: next valid_o=0, flags 0, state RUN, instr_i dropped; stall_o=0.
REQ-031 instr_valid_i=0 SHALL never trigger a hazard; bubble registered.

Reset
REQ-032 rst=1 at any cycle, including mid-LU_WAIT, SHALL next cycle give valid_o=0, all outputs 0, state RUN; stall_o=0 while rst=1.

Verification
REQ-033 ADDI x5,x1,-3 (0xFFD08293) valid, pc=0x100 -> next cycle valid_o=1, rd_o=5, rs1_o=1, imm_o=0xFFFFFFFD, reg_we_o=1, alu_op_o=0, pc_o=0x100.
REQ-034 LW x6,0(x2) then ADD x7,x6,x3 -> stall_o=1 two cycles, two bubbles, ADD emitted third cycle with rs1_o=6.
REQ-035 LW x0 then ADD using x0 -> no stall, no bubble.
REQ-036 stall_i=1 three cycles with valid bundle held -> outputs unchanged, stall_o=1; release -> next instr on following cycle.
REQ-037 flush_i=1 during LU_WAIT with stall_i=1 -> next cycle valid_o=0, state RUN, stall_o=0.
REQ-038 instr 0xFFFFFFFF valid -> illegal_o=1, reg_we_o=0, rd_o=0; rst mid-sequence -> all outputs 0 next cycle.
